// File: rtl/uart_rx.sv
// uart_rx: 8-bit asynchronous serial receiver, LSB first, one stop bit.
// The line is double-flop synchronized and every bit is sampled once at its
// midpoint, timed by a baud counter that restarts on each state change.
// Optional feature: define UART_RX_PARITY_EN to expect an even-parity bit
// between data bit 7 and the stop bit. Without it frames are 8N1 and
// parity_error is tied low.
//
// Output handshake: data_valid, frame_error and parity_error are mutually
// exclusive single-cycle pulses with no back-pressure. data only changes in
// the cycle data_valid is high and holds its value otherwise.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_error,
  output logic       parity_error,
  output logic [2:0] fsm_state
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'((CLKS_PER_BIT / 2) - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY    = 3'd3;
`endif
  localparam logic [2:0] STOP      = 3'd4;
  localparam logic [2:0] WAIT_HIGH = 3'd5;

  logic          rx_meta;
  logic          rx_s;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          parity_ok;

`ifdef UART_RX_PARITY_EN
  logic          parity_bit;
  logic          parity_err_q;

  // Even parity: the received parity bit must equal the XOR of the data bits.
  assign parity_ok    = (^shift) == parity_bit;
  assign parity_error = parity_err_q;
`else
  assign parity_ok    = 1'b1;
  assign parity_error = 1'b0;
`endif

  assign fsm_state = state;

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Frame FSM: midpoint sampling, shift register, result registers and pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      data         <= '0;
      data_valid   <= 1'b0;
      frame_error  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit   <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      data_valid   <= 1'b0;
      frame_error  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          // Half a bit in: a line still low is a real start bit.
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt            <= '0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt        <= '0;
            parity_bit <= rx_s;
            state      <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          // A low stop bit wins over any parity result.
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              if (parity_ok) begin
                data       <= shift;
                data_valid <= 1'b1;
              end else begin
`ifdef UART_RX_PARITY_EN
                parity_err_q <= 1'b1;
`endif
              end
            end else begin
              frame_error <= 1'b1;
              state       <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          // A held-low line (break) reports once and then waits here.
          cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: random and directed frames against a frame-level model.
// Each sent frame pushes its expected outcome and stop-bit midpoint cycle.
// A negedge monitor pops one entry per output pulse.
module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam logic [1:0] K_VALID = 2'd1;
  localparam logic [1:0] K_FRAME = 2'd2;
  localparam logic [1:0] K_PAR   = 2'd3;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_error;
  logic       parity_error;
  logic [2:0] fsm_state;

  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  logic [9:0] exp_q[$];
  int         exp_t_q[$];
  logic [7:0] held = 8'h00;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clock        (clock),
    .reset        (reset),
    .rx           (rx),
    .data         (data),
    .data_valid   (data_valid),
    .frame_error  (frame_error),
    .parity_error (parity_error),
    .fsm_state    (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached with %0d expected events pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  task automatic hold_bit(input logic v);
    rx = v;
    repeat (CPB) @(negedge clock);
  endtask

  // Reference model: outcome of a frame from its stop bit and parity bit.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_good,
                            input bit expect_it);
    logic [1:0] kind;
    int         bits_before_stop;
    int         mid;
    bits_before_stop = PAR_EN ? 10 : 9;
    mid = cyc + bits_before_stop * CPB + CPB / 2;
    if (!stop) kind = K_FRAME;
    else if (PAR_EN && !par_good) kind = K_PAR;
    else kind = K_VALID;
    if (expect_it) begin
      exp_q.push_back({kind, b});
      exp_t_q.push_back(mid);
    end
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(b[i]);
    if (PAR_EN) hold_bit(par_good ? ^b : ~^b);
    hold_bit(stop);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    int         nh;
    logic [1:0] act_kind;
    logic [9:0] e;
    int         t;
    int         lat;
    nh = int'(data_valid) + int'(frame_error) + int'(parity_error);
    act_kind = data_valid ? K_VALID : frame_error ? K_FRAME : parity_error ? K_PAR : 2'd0;
    if (reset) begin
      held = 8'h00;
    end else if (nh == 0) begin
      check("data_hold", {24'd0, data}, {24'd0, held});
    end else begin
      check("pulse_exclusive", nh, 1);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got kind %0d data %0h expected no pulse (cycle %0d)",
                 act_kind, data, cyc);
      end else begin
        e = exp_q.pop_front();
        t = exp_t_q.pop_front();
        lat = cyc - t;
        check("pulse_kind", {30'd0, act_kind}, {30'd0, e[9:8]});
        checks++;
        if (lat < 2 || lat > 3) begin
          errors++;
          $display("FAIL pulse_latency: got %0d cycles after stop midpoint expected 2..3", lat);
        end
        if (e[9:8] == K_VALID) held = e[7:0];
        check("pulse_data", {24'd0, data}, {24'd0, held});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] b;
    logic       stop;
    logic       pg;
    logic       prev_stop;
    reset = 1'b1;
    rx    = 1'b1;
    repeat (4) @(negedge clock);
    check("reset_data", {24'd0, data}, 32'd0);
    check("reset_valid", {31'd0, data_valid}, 32'd0);
    check("reset_frame_error", {31'd0, frame_error}, 32'd0);
    check("reset_parity_error", {31'd0, parity_error}, 32'd0);
    reset = 1'b0;
    idle(10);

    // Single frame, then two back-to-back frames.
    send_frame(8'h55, 1'b1, 1'b1, 1'b1);
    idle(10);
    send_frame(8'hA3, 1'b1, 1'b1, 1'b1);
    send_frame(8'h0F, 1'b1, 1'b1, 1'b1);
    idle(10);

    // False start: 5-cycle low glitch is rejected at the start midpoint.
    rx = 1'b0;
    repeat (5) @(negedge clock);
    idle(20);
    send_frame(8'h7E, 1'b1, 1'b1, 1'b1);
    idle(10);

    // Bad stop bit followed by a long break.
    send_frame(8'hC4, 1'b0, 1'b1, 1'b1);
    rx = 1'b0;
    repeat (400) @(negedge clock);
    idle(10);
    send_frame(8'h12, 1'b1, 1'b1, 1'b1);
    idle(10);

    // Reset during data bit 4 of a 0xFF frame.
    fork
      send_frame(8'hFF, 1'b1, 1'b1, 1'b0);
      begin
        repeat (CPB * 5 + 4) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
      end
    join
    check("midreset_data", {24'd0, data}, 32'd0);
    check("midreset_valid", {31'd0, data_valid}, 32'd0);
    check("midreset_frame_error", {31'd0, frame_error}, 32'd0);
    check("midreset_parity_error", {31'd0, parity_error}, 32'd0);
    idle(10);
    send_frame(8'h33, 1'b1, 1'b1, 1'b1);
    idle(10);

    // Parity bit wrong, then right (both plain frames without the option).
    send_frame(8'h01, 1'b1, 1'b0, 1'b1);
    idle(5);
    send_frame(8'h01, 1'b1, 1'b1, 1'b1);

    // Random frames with random gaps, stop bits and parity bits.
    prev_stop = 1'b1;
    for (int n = 0; n < 30; n++) begin
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 7) != 0);
      pg   = ($urandom_range(0, 3) != 0);
      if (prev_stop) idle($urandom_range(0, 12));
      else idle($urandom_range(2, 12));
      send_frame(b, stop, pg, 1'b1);
      prev_stop = stop;
    end
    idle(20);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clock);
    check("drain_pending", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
